// File: rtl/track_play_sequencer.sv
// Playback sequencer for the two note-track RAMs.
// Walks a shared read address from 0 to the end of the selected recording.
// Each note is held for TICKS_PER_NOTE divider strobes.
// Registered per-track tones are presented to the audio block.
//
// Handshake: play and stop are single-cycle requests with no ready signal.
// play is accepted only in IDLE, and only when stop is low in the same cycle.
// stop is honoured in every non-IDLE state.
// finish is a one-cycle pulse, with no acknowledge.
module track_play_sequencer #(
    parameter int ADDR_W         = 6,
    parameter int DATA_W         = 8,
    parameter int TICKS_PER_NOTE = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              play,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] limit1,
    input  logic [ADDR_W-1:0] limit2,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              cs1,
    output logic              cs2,
    output logic [DATA_W-1:0] tone1,
    output logic [DATA_W-1:0] tone2,
    output logic              busy,
    output logic              finish
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_NOTE - 1);

    state_t            state, next_state;
    logic [1:0]        mode_r;
    logic [ADDR_W-1:0] limit1_r, limit2_r;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        tick_cnt;
    logic              fin_empty_r;

    logic [ADDR_W-1:0] len_in, len_r;
    logic              play_go, start, empty_play, abort, tick_hit, last_note;

    // Effective recording length for a given mode and pair of limits.
    function automatic logic [ADDR_W-1:0] eff_len(input logic [1:0]        m,
                                                  input logic [ADDR_W-1:0] l1,
                                                  input logic [ADDR_W-1:0] l2);
        case (m)
            2'b01:   eff_len = l1;
            2'b10:   eff_len = l2;
            2'b11:   eff_len = (l1 > l2) ? l1 : l2;
            default: eff_len = '0;
        endcase
    endfunction

    assign len_in     = eff_len(mode, limit1, limit2);
    assign len_r      = eff_len(mode_r, limit1_r, limit2_r);
    assign play_go    = (state == S_IDLE) && play && !stop;
    assign start      = play_go && (len_in != '0);
    assign empty_play = play_go && (len_in == '0);
    assign abort      = stop && (state != S_IDLE);
    assign tick_hit   = tick && (tick_cnt == TICK_LAST);
    assign last_note  = (idx == len_r - 1'b1);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; an abort overrides the normal walk.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) next_state = S_FETCH;
                S_FETCH: next_state = S_LATCH;
                S_LATCH: next_state = S_HOLD;
                S_HOLD:  if (tick_hit) next_state = last_note ? S_DONE : S_FETCH;
                S_DONE:  next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from the current state and the captured mode.
    always_comb begin
        busy    = (state == S_FETCH) || (state == S_LATCH) || (state == S_HOLD);
        rd_en   = (state == S_FETCH);
        rd_addr = (state == S_FETCH) ? idx : '0;
        cs1     = busy && mode_r[0];
        cs2     = busy && mode_r[1];
        finish  = (state == S_DONE) || fin_empty_r;
    end

    // Datapath: capture at play, note index, tick counter and tone registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mode_r      <= '0;
            limit1_r    <= '0;
            limit2_r    <= '0;
            idx         <= '0;
            tick_cnt    <= '0;
            tone1       <= '0;
            tone2       <= '0;
            fin_empty_r <= 1'b0;
        end else begin
            fin_empty_r <= empty_play;
            if (play_go) begin
                mode_r   <= mode;
                limit1_r <= limit1;
                limit2_r <= limit2;
                idx      <= '0;
            end
            case (state)
                S_LATCH: begin
                    // A track shorter than the mix length plays silence past its end.
                    tone1    <= (mode_r[0] && (idx < limit1_r)) ? data1 : '0;
                    tone2    <= (mode_r[1] && (idx < limit2_r)) ? data2 : '0;
                    tick_cnt <= '0;
                end
                S_HOLD: begin
                    if (tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (last_note) begin
                                tone1 <= '0;
                                tone2 <= '0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // Silence immediately on abort, whatever the state was doing.
            if (abort) begin
                tone1 <= '0;
                tone2 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_track_play_sequencer.sv
// Directed testbench for track_play_sequencer with simple registered RAM models.
module tb_track_play_sequencer;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int TPN    = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              tick, play, stop;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] limit1, limit2;
    logic [DATA_W-1:0] data1, data2;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en, cs1, cs2, busy, finish;
    logic [DATA_W-1:0] tone1, tone2;

    logic [DATA_W-1:0] ram1 [64];
    logic [DATA_W-1:0] ram2 [64];

    int n_checks = 0;
    int n_fail   = 0;

    track_play_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICKS_PER_NOTE(TPN)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .play(play), .stop(stop),
        .mode(mode), .limit1(limit1), .limit2(limit2),
        .data1(data1), .data2(data2),
        .rd_addr(rd_addr), .rd_en(rd_en), .cs1(cs1), .cs2(cs2),
        .tone1(tone1), .tone2(tone2), .busy(busy), .finish(finish)
    );

    // Clock and registered RAM read models (1-cycle latency).
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rd_en) begin
            data1 <= ram1[rd_addr];
            data2 <= ram2[rd_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_rd_en"},   32'(rd_en),   0);
        check({tag, "_cs1"},     32'(cs1),     0);
        check({tag, "_cs2"},     32'(cs2),     0);
        check({tag, "_tone1"},   32'(tone1),   0);
        check({tag, "_tone2"},   32'(tone2),   0);
        check({tag, "_busy"},    32'(busy),    0);
        check({tag, "_finish"},  32'(finish),  0);
    endtask

    // Entered in the FETCH cycle of a note. Ticks in FETCH/LATCH must be ignored.
    task automatic run_note(input logic [5:0] a, input logic [7:0] t1, input logic [7:0] t2,
                            input logic c1, input logic c2, input bit last);
        check($sformatf("n%0d_fetch_rd_en", a), 32'(rd_en), 1);
        check($sformatf("n%0d_fetch_addr", a),  32'(rd_addr), 32'(a));
        check($sformatf("n%0d_fetch_busy", a),  32'(busy), 1);
        check($sformatf("n%0d_cs1", a),         32'(cs1), 32'(c1));
        check($sformatf("n%0d_cs2", a),         32'(cs2), 32'(c2));
        tick = 1'b1;
        step();
        play = 1'b0;
        check($sformatf("n%0d_latch_rd_en", a), 32'(rd_en), 0);
        check($sformatf("n%0d_latch_busy", a),  32'(busy), 1);
        step();
        tick = 1'b0;
        check($sformatf("n%0d_tone1", a), 32'(tone1), 32'(t1));
        check($sformatf("n%0d_tone2", a), 32'(tone2), 32'(t2));
        for (int k = 0; k < TPN; k++) begin
            step();
            check($sformatf("n%0d_hold_tone1", a), 32'(tone1), 32'(t1));
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (k < TPN - 1) begin
                check($sformatf("n%0d_hold_rd_en", a), 32'(rd_en), 0);
                check($sformatf("n%0d_hold_busy", a),  32'(busy), 1);
                check($sformatf("n%0d_hold_tone2", a), 32'(tone2), 32'(t2));
            end
        end
        if (last) begin
            check($sformatf("n%0d_done_finish", a), 32'(finish), 1);
            check($sformatf("n%0d_done_busy", a),   32'(busy), 0);
            check($sformatf("n%0d_done_tone1", a),  32'(tone1), 0);
            check($sformatf("n%0d_done_tone2", a),  32'(tone2), 0);
            check($sformatf("n%0d_done_cs1", a),    32'(cs1), 0);
            step();
            check($sformatf("n%0d_after_finish", a), 32'(finish), 0);
            check($sformatf("n%0d_after_rd_en", a),  32'(rd_en), 0);
        end
    endtask

    task automatic pulse_play();
        play = 1'b1;
        step();
        play = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; tick = 1'b0; play = 1'b0; stop = 1'b0;
        mode = 2'b00; limit1 = '0; limit2 = '0;
        data1 = '0; data2 = '0;
        for (int i = 0; i < 64; i++) begin
            ram1[i] = 8'hFF;
            ram2[i] = 8'hEE;
        end

        // Reset state.
        repeat (3) step();
        check_quiet("reset");
        reset = 1'b1;
        step();

        // Basic track1 playback.
        ram1[0] = 8'h01; ram1[1] = 8'h02; ram1[2] = 8'h04;
        mode = 2'b01; limit1 = 6'd3; limit2 = 6'd0;
        pulse_play();
        run_note(6'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        run_note(6'd1, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0);
        run_note(6'd2, 8'h04, 8'h00, 1'b1, 1'b0, 1'b1);

        // Mix with unequal lengths; track1 must go silent past its limit.
        ram1[0] = 8'h08; ram1[1] = 8'h10; ram1[2] = 8'hFF; ram1[3] = 8'hFF;
        ram2[0] = 8'h01; ram2[1] = 8'h02; ram2[2] = 8'h04; ram2[3] = 8'h80;
        mode = 2'b11; limit1 = 6'd2; limit2 = 6'd4;
        pulse_play();
        run_note(6'd0, 8'h08, 8'h01, 1'b1, 1'b1, 1'b0);
        run_note(6'd1, 8'h10, 8'h02, 1'b1, 1'b1, 1'b0);
        run_note(6'd2, 8'h00, 8'h04, 1'b1, 1'b1, 1'b0);
        run_note(6'd3, 8'h00, 8'h80, 1'b1, 1'b1, 1'b1);

        // Empty play: mode 10 with limit2=0, then mode 00.
        mode = 2'b10; limit1 = 6'd5; limit2 = 6'd0;
        pulse_play();
        check("empty_finish", 32'(finish), 1);
        check("empty_busy",   32'(busy),   0);
        check("empty_rd_en",  32'(rd_en),  0);
        step();
        check("empty_finish_once", 32'(finish), 0);
        check("empty_busy2",       32'(busy),   0);
        mode = 2'b00;
        pulse_play();
        check("none_finish", 32'(finish), 1);
        check("none_rd_en",  32'(rd_en),  0);
        step();
        check("none_finish_once", 32'(finish), 0);

        // Stop during HOLD of idx 1, then restart from address 0.
        ram1[0] = 8'h01; ram1[1] = 8'h02; ram1[2] = 8'h04;
        mode = 2'b01; limit1 = 6'd3; limit2 = 6'd0;
        pulse_play();
        run_note(6'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        step();
        step();
        check("stop_pre_tone1", 32'(tone1), 8'h02);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_quiet("stop");
        step();
        check("stop_no_finish", 32'(finish), 0);
        pulse_play();
        check("restart_rd_en", 32'(rd_en),   1);
        check("restart_addr",  32'(rd_addr), 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_quiet("stop_fetch");

        // Reset during HOLD.
        pulse_play();
        step();
        step();
        check("rst_pre_tone1", 32'(tone1), 8'h01);
        reset = 1'b0;
        step();
        check_quiet("mid_reset");
        reset = 1'b1;
        step();

        // Concurrent play and stop in IDLE: stop wins.
        play = 1'b1; stop = 1'b1;
        step();
        play = 1'b0; stop = 1'b0;
        check_quiet("play_stop");
        step();
        check_quiet("play_stop2");

        // Inputs frozen at play; play while busy is ignored.
        mode = 2'b01; limit1 = 6'd2; limit2 = 6'd0;
        pulse_play();
        mode = 2'b11; limit1 = 6'd3; limit2 = 6'd5;
        run_note(6'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        play = 1'b1;
        run_note(6'd1, 8'h02, 8'h00, 1'b1, 1'b0, 1'b1);
        step();
        check_quiet("freeze_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
